// File: rtl/csa_fan_pkg.sv
// csa_fan_pkg: shared types and width helpers for the streaming carry-save FAN.
package csa_fan_pkg;

  // Group state: no open group, or a group is being accumulated.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Accumulator width: operand width, plus lane growth, plus beat growth.
  function automatic int calc_acc_w(input int w, input int lanes, input int cw);
    return w + $clog2(lanes) + cw;
  endfunction

  localparam int DEF_LANES = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_CW    = 8;
  localparam int DEF_ACC_W = calc_acc_w(DEF_W, DEF_LANES, DEF_CW);

  typedef logic [DEF_ACC_W-1:0] acc_t;
  typedef logic [DEF_CW-1:0]    beat_cnt_t;

endpackage

// File: rtl/csa_compress_tree.sv
// csa_compress_tree: combinational N_IN -> 2 Wallace-style carry-save reduction.
// Each level packs inputs into groups of three through 3:2 compressors and
// passes leftovers straight through; the module recurses until two rows remain.
// Carries out of the MSB are dropped (modulo 2^WD arithmetic).
module csa_compress_tree #(
  parameter int N_IN = 6,
  parameter int WD   = 12
) (
  input  logic [N_IN-1:0][WD-1:0] ops_i,
  output logic [WD-1:0]           sum_o,
  output logic [WD-1:0]           carry_o
);

  if (N_IN == 2) begin : g_leaf
    assign sum_o   = ops_i[0];
    assign carry_o = ops_i[1];
  end else begin : g_level
    localparam int NG    = N_IN / 3;
    localparam int NR    = N_IN % 3;
    localparam int N_NXT = 2 * NG + NR;

    logic [N_NXT-1:0][WD-1:0] nxt;

    for (genvar g = 0; g < NG; g++) begin : g_csa
      assign nxt[2*g]   = ops_i[3*g] ^ ops_i[3*g+1] ^ ops_i[3*g+2];
      assign nxt[2*g+1] = ((ops_i[3*g] & ops_i[3*g+1]) |
                           (ops_i[3*g] & ops_i[3*g+2]) |
                           (ops_i[3*g+1] & ops_i[3*g+2])) << 1;
    end

    for (genvar r = 0; r < NR; r++) begin : g_pass
      assign nxt[2*NG+r] = ops_i[3*NG+r];
    end

    csa_compress_tree #(
      .N_IN (N_NXT),
      .WD   (WD)
    ) u_next (
      .ops_i   (nxt),
      .sum_o   (sum_o),
      .carry_o (carry_o)
    );
  end

endmodule

// File: rtl/ks_adder.sv
// ks_adder: Kogge-Stone parallel-prefix adder, carry-in 0, carry-out dropped.
module ks_adder #(
  parameter int WD = 12
) (
  input  logic [WD-1:0] a_i,
  input  logic [WD-1:0] b_i,
  output logic [WD-1:0] sum_o
);

  logic [WD-1:0] gen;
  logic [WD-1:0] prop;
  logic [WD-1:0] prop0;

  // Prefix tree: each pass doubles the span of every generate/propagate term.
  always_comb begin
    gen   = a_i & b_i;
    prop  = a_i ^ b_i;
    prop0 = prop;
    for (int d = 1; d < WD; d = d * 2) begin
      gen  = gen | (prop & (gen << d));
      prop = prop & (prop << d);
    end
    sum_o = prop0 ^ (gen << 1);
  end

endmodule

// File: rtl/csa_fan_stream.sv
// csa_fan_stream: streaming carry-save reduction of LANES operands per beat,
// one resolved sum per vector group.
// Optional feature: define CSA_FAN_STREAM_SIGNED_EN for two's-complement
// operands (sign-extended before compression); otherwise zero-extended.
//
// Handshakes: a beat transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. Producers
// hold data stable while valid is high and not yet accepted; in_ready is a
// combinational function of local state and out_ready only, never of in_valid.
module csa_fan_stream
  import csa_fan_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int V     = 3,
  parameter int CW    = 8,
  parameter int ACC_W = calc_acc_w(W, LANES, CW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0][W-1:0] in_operands,
  input  logic [V-1:0]            in_vec_id,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic [V-1:0]            out_vec_id,
  output logic [CW-1:0]           out_beats,
  output logic                    out_ovf,
  output logic                    dbg_state_o
);

  localparam logic [CW-1:0] BEAT_MAX = '1;
  localparam logic [CW-1:0] BEAT_ONE = CW'(1);

  // Group state
  state_e           state_q;
  logic [V-1:0]     cur_id_q;
  logic [ACC_W-1:0] acc_s_q;
  logic [ACC_W-1:0] acc_c_q;
  logic [CW-1:0]    beats_q;
  logic             ovf_q;

  // One-entry pending single-beat group
  logic             pend_q;
  logic [ACC_W-1:0] pend_s_q;
  logic [ACC_W-1:0] pend_c_q;
  logic [V-1:0]     pend_id_q;

  // Output register
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [V-1:0]     out_vec_id_q;
  logic [CW-1:0]    out_beats_q;
  logic             out_ovf_q;

  logic out_free;
  logic accept;
  logic same_grp;

  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = rst_n & ~pend_q & out_free;
  assign accept   = in_valid & in_ready;
  assign same_grp = (state_q == ACCUM) && (in_vec_id == cur_id_q);

  // Operand extension plus the accumulator rows (zeroed when a group opens).
  logic [LANES+1:0][ACC_W-1:0] tree_in;
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
`ifdef CSA_FAN_STREAM_SIGNED_EN
      tree_in[l] = {{(ACC_W-W){in_operands[l][W-1]}}, in_operands[l]};
`else
      tree_in[l] = {{(ACC_W-W){1'b0}}, in_operands[l]};
`endif
    end
    tree_in[LANES]   = same_grp ? acc_s_q : '0;
    tree_in[LANES+1] = same_grp ? acc_c_q : '0;
  end

  logic [ACC_W-1:0] new_s;
  logic [ACC_W-1:0] new_c;

  csa_compress_tree #(
    .N_IN (LANES + 2),
    .WD   (ACC_W)
  ) u_tree (
    .ops_i   (tree_in),
    .sum_o   (new_s),
    .carry_o (new_c)
  );

  logic          beats_sat;
  logic [CW-1:0] beats_inc;
  logic          ovf_inc;

  assign beats_sat = (beats_q == BEAT_MAX);
  assign beats_inc = beats_sat ? beats_q : beats_q + BEAT_ONE;
  // Sticky: set once a beat arrives after the counter already hit its ceiling.
  assign ovf_inc   = ovf_q | beats_sat;

  logic             emit_en;
  logic [ACC_W-1:0] emit_s;
  logic [ACC_W-1:0] emit_c;
  logic [V-1:0]     out_vec_id_d;
  logic [CW-1:0]    out_beats_d;
  logic             out_ovf_d;
  logic [ACC_W-1:0] out_sum_d;

  // Emit selection: pending group first, otherwise whichever group this beat closes.
  always_comb begin
    emit_en      = 1'b0;
    emit_s       = new_s;
    emit_c       = new_c;
    out_vec_id_d = in_vec_id;
    out_beats_d  = BEAT_ONE;
    out_ovf_d    = 1'b0;
    if (pend_q && out_free) begin
      emit_en      = 1'b1;
      emit_s       = pend_s_q;
      emit_c       = pend_c_q;
      out_vec_id_d = pend_id_q;
    end else if (accept) begin
      if (state_q == IDLE) begin
        emit_en = in_last;
      end else if (same_grp) begin
        emit_en      = in_last;
        out_vec_id_d = cur_id_q;
        out_beats_d  = beats_inc;
        out_ovf_d    = ovf_inc;
      end else begin
        emit_en      = 1'b1;
        emit_s       = acc_s_q;
        emit_c       = acc_c_q;
        out_vec_id_d = cur_id_q;
        out_beats_d  = beats_q;
        out_ovf_d    = ovf_q;
      end
    end
  end

  ks_adder #(
    .WD (ACC_W)
  ) u_resolve (
    .a_i   (emit_s),
    .b_i   (emit_c),
    .sum_o (out_sum_d)
  );

  // Group FSM, pending slot and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_id_q     <= '0;
      acc_s_q      <= '0;
      acc_c_q      <= '0;
      beats_q      <= '0;
      ovf_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_s_q     <= '0;
      pend_c_q     <= '0;
      pend_id_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_vec_id_q <= '0;
      out_beats_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      if (pend_q && out_free) begin
        pend_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (!in_last) begin
              state_q  <= ACCUM;
              acc_s_q  <= new_s;
              acc_c_q  <= new_c;
              cur_id_q <= in_vec_id;
              beats_q  <= BEAT_ONE;
              ovf_q    <= 1'b0;
            end
          end
          ACCUM: begin
            if (same_grp) begin
              if (in_last) begin
                state_q <= IDLE;
              end else begin
                acc_s_q <= new_s;
                acc_c_q <= new_c;
                beats_q <= beats_inc;
                ovf_q   <= ovf_inc;
              end
            end else if (in_last) begin
              state_q   <= IDLE;
              pend_q    <= 1'b1;
              pend_s_q  <= new_s;
              pend_c_q  <= new_c;
              pend_id_q <= in_vec_id;
            end else begin
              acc_s_q  <= new_s;
              acc_c_q  <= new_c;
              cur_id_q <= in_vec_id;
              beats_q  <= BEAT_ONE;
              ovf_q    <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      if (emit_en) begin
        out_valid_q  <= 1'b1;
        out_sum_q    <= out_sum_d;
        out_vec_id_q <= out_vec_id_d;
        out_beats_q  <= out_beats_d;
        out_ovf_q    <= out_ovf_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_vec_id  = out_vec_id_q;
  assign out_beats   = out_beats_q;
  assign out_ovf     = out_ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_csa_fan_stream.sv
// tb_csa_fan_stream: directed bench with a group-level reference model.
module tb_csa_fan_stream;

  localparam int LANES = 4;
  localparam int W     = 8;
  localparam int V     = 3;
  localparam int CW    = 2;
  localparam int ACC_W = W + $clog2(LANES) + CW;
  localparam int EXP_W = ACC_W + V + CW + 1;
  localparam int MAXB  = (1 << CW) - 1;

  typedef logic [LANES-1:0][W-1:0] beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  beat_t            in_operands = '0;
  logic [V-1:0]     in_vec_id = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [V-1:0]     out_vec_id;
  logic [CW-1:0]    out_beats;
  logic             out_ovf;
  logic             dbg_state;

  int errors = 0;
  int checks = 0;

  logic [EXP_W-1:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  csa_fan_stream #(
    .LANES (LANES),
    .W     (W),
    .V     (V),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_operands (in_operands),
    .in_vec_id   (in_vec_id),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_vec_id  (out_vec_id),
    .out_beats   (out_beats),
    .out_ovf     (out_ovf),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic beat_t mk(input int a, input int b, input int c, input int d);
    beat_t r;
    r[0] = W'(a);
    r[1] = W'(b);
    r[2] = W'(c);
    r[3] = W'(d);
    return r;
  endfunction

  // Reference model: a group is just a running integer sum and beat count.
  bit           m_open = 1'b0;
  logic [V-1:0] m_id = '0;
  longint       m_sum = 0;
  int           m_n = 0;

  function automatic longint beat_sum(input beat_t b);
    longint s = 0;
    for (int l = 0; l < LANES; l++) begin
`ifdef CSA_FAN_STREAM_SIGNED_EN
      s += longint'($signed(b[l]));
`else
      s += longint'(b[l]);
`endif
    end
    return s;
  endfunction

  task automatic push_group(input logic [V-1:0] id, input longint sum, input int n);
    logic [63:0]      s64;
    logic [ACC_W-1:0] s;
    logic [CW-1:0]    b;
    logic             o;
    s64 = sum;
    s   = s64[ACC_W-1:0];
    b   = (n > MAXB) ? CW'(MAXB) : CW'(n);
    o   = (n > MAXB);
    exp_q.push_back({s, id, b, o});
  endtask

  task automatic model_beat(input beat_t b, input logic [V-1:0] id, input logic last);
    longint bs = beat_sum(b);
    if (m_open && id == m_id) begin
      m_sum += bs;
      m_n++;
      if (last) begin
        push_group(m_id, m_sum, m_n);
        m_open = 1'b0;
      end
    end else begin
      if (m_open) push_group(m_id, m_sum, m_n);
      if (last) begin
        push_group(id, bs, 1);
        m_open = 1'b0;
      end else begin
        m_open = 1'b1;
        m_id   = id;
        m_sum  = bs;
        m_n    = 1;
      end
    end
  endtask

  // Scoreboard: compare every transferred result against the model, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_open = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected sum=%0d id=%0d", out_sum, out_vec_id);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          if ({out_sum, out_vec_id, out_beats, out_ovf} !== e) begin
            errors++;
            $display("FAIL result: got sum=%0d id=%0d beats=%0d ovf=%0d, required sum=%0d id=%0d beats=%0d ovf=%0d",
                     out_sum, out_vec_id, out_beats, out_ovf,
                     e[EXP_W-1 -: ACC_W], e[CW+V : CW+1], e[CW:1], e[0]);
          end
        end
      end
      if (in_valid && in_ready) model_beat(in_operands, in_vec_id, in_last);
    end
  end

  // Driver: present a beat and hold it until accepted.
  task automatic send(input beat_t b, input logic [V-1:0] id, input logic last);
    int  n = 0;
    bit  done = 1'b0;
    in_valid    = 1'b1;
    in_operands = b;
    in_vec_id   = id;
    in_last     = last;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept after %0d cycles, required accept", n);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint t0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_vec_id", out_vec_id, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 0);
    align();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_state", dbg_state, 0);
    align();

    // Two-beat group
    send(mk(1, 2, 3, 4), 3'd5, 1'b0);
    send(mk(10, 20, 30, 40), 3'd5, 1'b1);
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 110);
    check("t1_id", out_vec_id, 5);
    check("t1_beats", out_beats, 2);
    check("t1_ovf", out_ovf, 0);
    align();

    // Id change closes a group; pending single-beat group follows
    send(mk(1, 1, 1, 1), 3'd1, 1'b0);
    send(mk(2, 2, 2, 2), 3'd2, 1'b1);
    @(negedge clk);
    check("t2_sum_a", out_sum, 4);
    check("t2_id_a", out_vec_id, 1);
    check("t2_ready_low", in_ready, 0);
    @(negedge clk);
    check("t2_valid_b", out_valid, 1);
    check("t2_sum_b", out_sum, 8);
    check("t2_id_b", out_vec_id, 2);
    check("t2_ready_back", in_ready, 1);
    align();

    // Backpressure
    out_ready = 1'b0;
    send(mk(5, 0, 0, 0), 3'd3, 1'b1);
    in_valid    = 1'b1;
    in_operands = mk(1, 2, 0, 0);
    in_vec_id   = 3'd4;
    in_last     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_held", in_ready, 0);
      check("t3_valid_held", out_valid, 1);
      check("t3_sum_held", out_sum, 5);
    end
    align();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_release", in_ready, 1);
    align();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("t3_next_valid", out_valid, 1);
    check("t3_next_sum", out_sum, 3);
    check("t3_next_id", out_vec_id, 4);
    align();

    // Beat counter saturation
    repeat (4) send(mk(255, 255, 255, 255), 3'd6, 1'b0);
    send(mk(255, 255, 255, 255), 3'd6, 1'b1);
    @(negedge clk);
    check("t4_sum", out_sum, 1004);
    check("t4_beats", out_beats, 3);
    check("t4_ovf", out_ovf, 1);
    align();

    // Back-to-back single-beat groups at full rate
    t0 = $time;
    send(mk(1, 0, 0, 0), 3'd1, 1'b1);
    send(mk(0, 2, 0, 0), 3'd2, 1'b1);
    send(mk(0, 0, 3, 0), 3'd3, 1'b1);
    check("t7_cycles", ($time - t0) / 10, 3);
    @(negedge clk);
    check("t7_last_sum", out_sum, 3);
    align();

    // Lane signedness
    send(mk(255, 254, 3, 252), 3'd2, 1'b1);
    @(negedge clk);
`ifdef CSA_FAN_STREAM_SIGNED_EN
    check("t6_sum", out_sum, 4092);
`else
    check("t6_sum", out_sum, 764);
`endif
    align();

    // Reset mid-group
    repeat (3) send(mk(9, 9, 9, 9), 3'd7, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_ready", in_ready, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_state", dbg_state, 0);
    align();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_stale", out_valid, 0);
    align();
    send(mk(1, 0, 0, 0), 3'd0, 1'b1);
    @(negedge clk);
    check("t5_valid", out_valid, 1);
    check("t5_sum", out_sum, 1);
    check("t5_id", out_vec_id, 0);
    check("t5_beats", out_beats, 1);
    align();

    // Drain and report
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
